// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The ALU_Control codes for the four Hi/Lo-writing instructions are kept here
// so the control unit and the EX stage agree on the mapping to op.
package muldiv_pkg;

    // Operation encodings on the op port
    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_MULU = 2'd1;
    localparam logic [1:0] OP_DIV  = 2'd2;
    localparam logic [1:0] OP_DIVU = 2'd3;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Control unit ALU_Control codes that route to this unit
    localparam logic [3:0] ALU_CTRL_MUL  = 4'b1010;
    localparam logic [3:0] ALU_CTRL_MULU = 4'b1011;
    localparam logic [3:0] ALU_CTRL_DIV  = 4'b1100;
    localparam logic [3:0] ALU_CTRL_DIVU = 4'b1101;

    // Translate an ALU_Control code into the op encoding of this unit
    function automatic logic [1:0] alu_ctrl_to_op(input logic [3:0] alu_ctrl);
        logic [1:0] result;
        case (alu_ctrl)
            ALU_CTRL_MUL:  result = OP_MUL;
            ALU_CTRL_MULU: result = OP_MULU;
            ALU_CTRL_DIV:  result = OP_DIV;
            ALU_CTRL_DIVU: result = OP_DIVU;
            default:       result = OP_MUL;
        endcase
        return result;
    endfunction

    // Divide ops have op[1] set; signed ops have op[0] clear
    function automatic logic op_is_div(input logic [1:0] op_code);
        return op_code[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op_code);
        return ~op_code[0];
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Final sign correction for the magnitude-only datapath.
// Multiply: the whole 2*WIDTH product takes sign_q.
// Divide: the low half (quotient) takes sign_q, the high half (remainder) sign_r.
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] raw,
    input  logic               sign_q,
    input  logic               sign_r,
    input  logic               is_div,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quo_neg;
    logic [WIDTH-1:0]   rem_neg;

    assign prod_neg = -raw;
    assign quo_neg  = -raw[WIDTH-1:0];
    assign rem_neg  = -raw[2*WIDTH-1:WIDTH];

    // Select the corrected halves according to the operation class
    always_comb begin
        hi = raw[2*WIDTH-1:WIDTH];
        lo = raw[WIDTH-1:0];
        if (is_div) begin
            lo = sign_q ? quo_neg : raw[WIDTH-1:0];
            hi = sign_r ? rem_neg : raw[2*WIDTH-1:WIDTH];
        end else if (sign_q) begin
            hi = prod_neg[2*WIDTH-1:WIDTH];
            lo = prod_neg[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine for the EX stage; owns the Hi/Lo registers.
// One result bit per cycle on operand magnitudes, signs applied in a final
// FIX cycle. A single accumulator serves both operations:
//   multiply: {partial product, remaining multiplier bits}, shifted right
//   divide:   {partial remainder, dividend/quotient bits}, shifted left
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               is_div_reg;
    logic               sign_q_reg;
    logic               sign_r_reg;
    logic               b_zero_reg;
    logic [WIDTH-1:0]   a_orig_reg;
    logic [WIDTH-1:0]   operand_reg;   // multiplicand |a| or divisor |b|
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic               busy_reg;
    logic               done_reg;
    logic               dbz_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;

    // Operand magnitudes, taken only for signed operations
    logic               signed_op;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    assign signed_op = op_is_signed(op);
    assign abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;

    // One iteration step of shift-add multiply or restoring divide
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   rem_diff;
    logic               rem_ge;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                  + {1'b0, (acc_reg[0] ? operand_reg : {WIDTH{1'b0}})};
        rem_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        rem_ge    = rem_shift >= {1'b0, operand_reg};
        // The difference is below the divisor whenever it is kept, so the
        // truncated low WIDTH bits are exact
        rem_diff  = rem_shift[WIDTH-1:0] - operand_reg;
        if (is_div_reg) begin
            if (rem_ge)
                acc_next = {rem_diff, acc_reg[WIDTH-2:0], 1'b1};
            else
                acc_next = {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
        end
    end

    // Signed result from the raw magnitude result
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    muldiv_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .raw    (acc_reg),
        .sign_q (sign_q_reg),
        .sign_r (sign_r_reg),
        .is_div (is_div_reg),
        .hi     (fix_hi),
        .lo     (fix_lo)
    );

    // Sequencer, datapath registers and registered outputs.
    // busy rises on the first CALC edge and falls on the FIX edge, so it is
    // low in the cycle where done is presented.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            is_div_reg  <= 1'b0;
            sign_q_reg  <= 1'b0;
            sign_r_reg  <= 1'b0;
            b_zero_reg  <= 1'b0;
            a_orig_reg  <= '0;
            operand_reg <= '0;
            acc_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            dbz_reg     <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            done_reg <= 1'b0;
            dbz_reg  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    busy_reg <= 1'b0;
                    if (start && !flush) begin
                        is_div_reg  <= op_is_div(op);
                        sign_q_reg  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sign_r_reg  <= signed_op & a[WIDTH-1];
                        b_zero_reg  <= (b == '0);
                        a_orig_reg  <= a;
                        operand_reg <= op_is_div(op) ? abs_b : abs_a;
                        acc_reg     <= op_is_div(op) ? {{WIDTH{1'b0}}, abs_a}
                                                     : {{WIDTH{1'b0}}, abs_b};
                        cnt_reg     <= CNT_W'(WIDTH - 1);
                        state_reg   <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        busy_reg <= 1'b1;
                        acc_reg  <= acc_next;
                        if (cnt_reg == '0)
                            state_reg <= S_FIX;
                        else
                            cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                S_FIX: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                    if (!flush) begin
                        done_reg <= 1'b1;
                        if (is_div_reg && b_zero_reg) begin
                            // Divide by zero: dividend to Hi, all ones to Lo
                            hi_reg  <= a_orig_reg;
                            lo_reg  <= {WIDTH{1'b1}};
                            dbz_reg <= 1'b1;
                        end else begin
                            hi_reg <= fix_hi;
                            lo_reg <= fix_lo;
                        end
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign div_by_zero = dbz_reg;
    assign hi          = hi_reg;
    assign lo          = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus random
// operations against an arithmetic reference model.
module tb_muldiv_unit;

    localparam logic [1:0] T_MUL  = 2'd0;
    localparam logic [1:0] T_MULU = 2'd1;
    localparam logic [1:0] T_DIV  = 2'd2;
    localparam logic [1:0] T_DIVU = 2'd3;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        flush   = 1'b0;
    logic [1:0]  op      = 2'd0;
    logic [31:0] a       = 32'd0;
    logic [31:0] b       = 32'd0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    muldiv_unit #(
        .WIDTH (32),
        .CNT_W (5)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS semantics in plain 64-bit arithmetic
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el, output logic ez);
        longint sx, sy, p, q, r;
        longint unsigned ux, uy, up;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        ez = 1'b0;
        eh = 32'd0;
        el = 32'd0;
        case (o)
            T_MUL: begin
                p  = sx * sy;
                eh = p[63:32];
                el = p[31:0];
            end
            T_MULU: begin
                up = ux * uy;
                eh = up[63:32];
                el = up[31:0];
            end
            default: begin
                if (y == 32'd0) begin
                    eh = x;
                    el = 32'hFFFF_FFFF;
                    ez = 1'b1;
                end else if (o == T_DIV) begin
                    q  = sx / sy;
                    r  = sx % sy;
                    el = q[31:0];
                    eh = r[31:0];
                end else begin
                    el = 32'(ux / uy);
                    eh = 32'(ux % uy);
                end
            end
        endcase
    endfunction

    // Run one operation, check latency, busy profile and results
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit poke_start);
        logic [31:0] eh, el;
        logic        ez;
        int          edges, busy_cycles;
        bit          got;
        model(o, x, y, eh, el, ez);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        edges = 0; busy_cycles = 0; got = 1'b0;
        while (!got && edges < 100) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            edges++;
            start = poke_start && (edges == 5);
            if (done) got = 1'b1;
        end
        start = 1'b0;
        check({tag, ".latency"}, 64'(edges), 64'd33);
        check({tag, ".busy_cycles"}, 64'(busy_cycles), 64'd32);
        check({tag, ".busy_at_done"}, {63'd0, busy}, 64'd0);
        check({tag, ".hi"}, {32'd0, hi}, {32'd0, eh});
        check({tag, ".lo"}, {32'd0, lo}, {32'd0, el});
        check({tag, ".dbz"}, {63'd0, div_by_zero}, {63'd0, ez});
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, {62'd0, done, div_by_zero}, 64'd0);
        check({tag, ".hold"}, {hi, lo}, {eh, el});
        $display("[TB] %s op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dbz=%0b",
                 tag, o, x, y, hi, lo, ez);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, failed=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount, bcount;
        logic [1:0]  ro;
        logic [31:0] rx, ry;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset.outputs", {busy, done, div_by_zero, hi, lo}, 67'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("reset.idle", {busy, done, div_by_zero, hi, lo}, 67'd0);

        // 1: full-width unsigned multiply, latency and busy profile
        do_op("tp1", T_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("tp1.hi_const", {32'd0, hi}, 64'hFFFF_FFFE);
        check("tp1.lo_const", {32'd0, lo}, 64'h0000_0001);

        // 2: signed multiply and signed divide
        do_op("tp2.mul", T_MUL, 32'hFFFF_FFFD, 32'd7, 1'b0);
        check("tp2.mul_lo_const", {32'd0, lo}, 64'hFFFF_FFEB);
        do_op("tp2.div", T_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("tp2.div_hilo_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // 3: divide by zero, then a normal divide
        do_op("tp3.dbz", T_DIVU, 32'd100, 32'd0, 1'b0);
        do_op("tp3.div", T_DIVU, 32'd100, 32'd7, 1'b0);
        do_op("tp3.sdbz", T_DIV, 32'h8000_0001, 32'd0, 1'b0);

        // 4: signed overflow
        do_op("tp4", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // 5: start while busy is ignored; flush aborts; start+flush in IDLE
        do_op("tp5.poke", T_MULU, 32'd12345, 32'd678, 1'b1);
        do_op("tp5.preload", T_MULU, 32'd3, 32'd5, 1'b0);
        @(negedge clk);
        start = 1'b1; op = T_DIVU; a = 32'd9; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("tp5.busy_before_flush", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("tp5.flush_busy", {63'd0, busy}, 64'd0);
        dcount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        check("tp5.flush_nodone", 64'(dcount), 64'd0);
        check("tp5.flush_hilo", {hi, lo}, 64'd15);
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = T_MULU; a = 32'd2; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        dcount = 0; bcount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dcount++;
            if (busy) bcount++;
        end
        check("tp5.sf_busy", 64'(bcount), 64'd0);
        check("tp5.sf_nodone", 64'(dcount), 64'd0);
        check("tp5.sf_hilo", {hi, lo}, 64'd15);
        $display("[TB] tp5 flush/start-while-busy sequence complete");

        // 6: asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1; op = T_MUL; a = 32'hFFFF_FFFD; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("tp6.busy_before_reset", {63'd0, busy}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("tp6.async_reset", {busy, done, div_by_zero, hi, lo}, 67'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        do_op("tp6.after", T_MULU, 32'd6, 32'd7, 1'b0);
        check("tp6.lo_const", {32'd0, lo}, 64'd42);

        // Random operations with a bias toward edge values
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       rx = 32'h8000_0000;
                1:       rx = 32'($urandom_range(0, 255));
                default: rx = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       ry = 32'd0;
                1:       ry = 32'hFFFF_FFFF;
                2:       ry = 32'($urandom_range(1, 15));
                default: ry = $urandom;
            endcase
            do_op($sformatf("rnd%0d", i), ro, rx, ry, (i % 5) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
